// File: rtl/main_fsm_pkg.sv
// main_fsm_pkg: shared RISC-V multicycle control encodings (package riscv_pkg).
package riscv_pkg;
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECR, EXECI, JAL, ALUWB, BEQ, ILLEGAL
  } statetype;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [1:0] ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_FUNCT = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00, RES_DATA = 2'b01, RES_ALURESULT = 2'b10;
  localparam logic [1:0] SRCA_PC = 2'b00, SRCA_OLDPC = 2'b01, SRCA_RS1 = 2'b10;
  localparam logic [1:0] SRCB_RS2 = 2'b00, SRCB_IMM = 2'b01, SRCB_FOUR = 2'b10;
endpackage

// File: rtl/main_fsm_if.sv
// main_fsm_if: opcode/stall inputs and datapath control outputs of the main FSM.
interface main_fsm_if;
  logic [6:0] op;
  logic       mem_ready;
  logic       PCUpdate, Branch, RegWrite, MemWrite, IRWrite, AdrSrc;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic       instr_done, illegal;
  modport master (
    output op, mem_ready,
    input  PCUpdate, Branch, RegWrite, MemWrite, IRWrite, AdrSrc,
    input  ResultSrc, ALUSrcA, ALUSrcB, ALUOp, instr_done, illegal
  );
  modport slave (
    input  op, mem_ready,
    output PCUpdate, Branch, RegWrite, MemWrite, IRWrite, AdrSrc,
    output ResultSrc, ALUSrcA, ALUSrcB, ALUOp, instr_done, illegal
  );
endinterface

// File: rtl/main_fsm.sv
// main_fsm: multicycle RISC-V control FSM with memory-ready stalls and a sticky illegal trap.
module main_fsm
  import riscv_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  main_fsm_if.slave  bus
);
  statetype state_q, state_d;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state_q <= FETCH;
    else          state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:    state_d = bus.mem_ready ? DECODE : FETCH;
      DECODE:
        case (bus.op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_R:         state_d = EXECR;
          OP_I:         state_d = EXECI;
          OP_BEQ:       state_d = BEQ;
          OP_JAL:       state_d = JAL;
          default:      state_d = ILLEGAL;
        endcase
      MEMADR:   state_d = (bus.op == OP_LW) ? MEMREAD : MEMWRITE;
      MEMREAD:  state_d = bus.mem_ready ? MEMWB : MEMREAD;
      MEMWRITE: state_d = bus.mem_ready ? FETCH : MEMWRITE;
      EXECR, EXECI, JAL: state_d = ALUWB;
      MEMWB, ALUWB, BEQ: state_d = FETCH;
      ILLEGAL:  state_d = ILLEGAL;
      default:  state_d = FETCH;
    endcase
  end
  always_comb begin
    bus.PCUpdate   = 1'b0;
    bus.Branch     = 1'b0;
    bus.RegWrite   = 1'b0;
    bus.MemWrite   = 1'b0;
    bus.IRWrite    = 1'b0;
    bus.AdrSrc     = 1'b0;
    bus.ResultSrc  = RES_ALUOUT;
    bus.ALUSrcA    = SRCA_PC;
    bus.ALUSrcB    = SRCB_RS2;
    bus.ALUOp      = ALU_ADD;
    bus.instr_done = 1'b0;
    bus.illegal    = state_q == ILLEGAL;
    case (state_q)
      FETCH: begin
        bus.ALUSrcB   = SRCB_FOUR;
        bus.ResultSrc = RES_ALURESULT;
        bus.IRWrite   = bus.mem_ready;
        bus.PCUpdate  = bus.mem_ready;
      end
      DECODE: begin
        bus.ALUSrcA = SRCA_OLDPC;
        bus.ALUSrcB = SRCB_IMM;
      end
      MEMADR: begin
        bus.ALUSrcA = SRCA_RS1;
        bus.ALUSrcB = SRCB_IMM;
      end
      MEMREAD: bus.AdrSrc = 1'b1;
      MEMWB: begin
        bus.ResultSrc  = RES_DATA;
        bus.RegWrite   = 1'b1;
        bus.instr_done = 1'b1;
      end
      MEMWRITE: begin
        bus.AdrSrc     = 1'b1;
        bus.MemWrite   = 1'b1;
        bus.instr_done = bus.mem_ready;
      end
      EXECR: begin
        bus.ALUSrcA = SRCA_RS1;
        bus.ALUOp   = ALU_FUNCT;
      end
      EXECI: begin
        bus.ALUSrcA = SRCA_RS1;
        bus.ALUSrcB = SRCB_IMM;
        bus.ALUOp   = ALU_FUNCT;
      end
      JAL: begin
        bus.ALUSrcA  = SRCA_OLDPC;
        bus.ALUSrcB  = SRCB_FOUR;
        bus.PCUpdate = 1'b1;
      end
      ALUWB: begin
        bus.RegWrite   = 1'b1;
        bus.instr_done = 1'b1;
      end
      BEQ: begin
        bus.ALUSrcA    = SRCA_RS1;
        bus.ALUOp      = ALU_SUB;
        bus.Branch     = 1'b1;
        bus.instr_done = 1'b1;
      end
      default: ;
    endcase
    // Async reset already parks the state in FETCH; this also kills the mem_ready-driven strobes.
    if (!reset_n) begin
      bus.PCUpdate   = 1'b0;
      bus.Branch     = 1'b0;
      bus.RegWrite   = 1'b0;
      bus.MemWrite   = 1'b0;
      bus.IRWrite    = 1'b0;
      bus.instr_done = 1'b0;
    end
  end
endmodule

// File: tb/tb_main_fsm.sv
// tb_main_fsm: randomized instruction stream with per-cycle expected control vectors in a scoreboard.
module tb_main_fsm;
  import riscv_pkg::*;
  localparam int P_F = 0, P_D = 1, P_MA = 2, P_MR = 3, P_MWB = 4, P_MW = 5, P_XR = 6,
                 P_XI = 7, P_J = 8, P_AWB = 9, P_B = 10, P_IL = 11, P_RST = 12;
  logic clk = 1'b0;
  logic reset_n;
  main_fsm_if intf ();
  main_fsm dut (.clk(clk), .reset_n(reset_n), .bus(intf));
  always #5 clk = ~clk;
  logic [15:0] exp_q[$];
  int total = 0, passed = 0, done_seen = 0, done_exp = 0;
  // Vector order: PCUpdate,Branch,RegWrite,MemWrite,IRWrite,AdrSrc,ResultSrc,ALUSrcA,ALUSrcB,ALUOp,instr_done,illegal
  function automatic logic [15:0] ev(int ph, bit mr);
    case (ph)
      P_F:   return {mr, 3'b000, mr, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0};
      P_D:   return {6'b0, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00};
      P_MA:  return {6'b0, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00};
      P_MR:  return {5'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
      P_MWB: return {2'b0, 1'b1, 3'b0, 2'b01, 6'b0, 1'b1, 1'b0};
      P_MW:  return {3'b0, 1'b1, 1'b0, 1'b1, 2'b00, 6'b0, mr, 1'b0};
      P_XR:  return {6'b0, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00};
      P_XI:  return {6'b0, 2'b00, 2'b10, 2'b01, 2'b10, 2'b00};
      P_J:   return {1'b1, 5'b0, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00};
      P_AWB: return {2'b0, 1'b1, 3'b0, 2'b00, 6'b0, 1'b1, 1'b0};
      P_B:   return {1'b0, 1'b1, 4'b0, 2'b00, 2'b10, 2'b00, 2'b01, 1'b1, 1'b0};
      P_IL:  return {15'b0, 1'b1};
      default: return {6'b0, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00};
    endcase
  endfunction
  task automatic cyc(int ph, bit mr, logic [6:0] o, bit rn);
    @(posedge clk);
    #1;
    reset_n = rn;
    intf.mem_ready = mr;
    intf.op = o;
    exp_q.push_back(ev(ph, mr));
  endtask
  function automatic bit rb();
    return bit'($urandom_range(0, 1));
  endfunction
  task automatic run_instr(logic [6:0] o, int fs, int ms);
    repeat (fs) cyc(P_F, 1'b0, 7'($urandom), 1'b1);
    cyc(P_F, 1'b1, 7'($urandom), 1'b1);
    cyc(P_D, rb(), o, 1'b1);
    case (o)
      OP_LW: begin
        cyc(P_MA, rb(), o, 1'b1);
        repeat (ms) cyc(P_MR, 1'b0, o, 1'b1);
        cyc(P_MR, 1'b1, o, 1'b1);
        cyc(P_MWB, rb(), o, 1'b1);
      end
      OP_SW: begin
        cyc(P_MA, rb(), o, 1'b1);
        repeat (ms) cyc(P_MW, 1'b0, o, 1'b1);
        cyc(P_MW, 1'b1, o, 1'b1);
      end
      OP_R:   begin cyc(P_XR, rb(), o, 1'b1); cyc(P_AWB, rb(), o, 1'b1); end
      OP_I:   begin cyc(P_XI, rb(), o, 1'b1); cyc(P_AWB, rb(), o, 1'b1); end
      OP_JAL: begin cyc(P_J, rb(), o, 1'b1);  cyc(P_AWB, rb(), o, 1'b1); end
      default: cyc(P_B, rb(), o, 1'b1);
    endcase
    done_exp++;
  endtask
  always @(negedge clk) begin
    logic [15:0] act, e;
    act = {intf.PCUpdate, intf.Branch, intf.RegWrite, intf.MemWrite, intf.IRWrite, intf.AdrSrc,
           intf.ResultSrc, intf.ALUSrcA, intf.ALUSrcB, intf.ALUOp, intf.instr_done, intf.illegal};
    if (intf.instr_done === 1'b1) done_seen++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (act !== e) $display("FAIL ctrl_vec t=%0t got=%b want=%b", $time, act, e);
      else passed++;
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  initial begin
    logic [6:0] legal [6];
    legal = '{OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL};
    reset_n = 1'b0;
    intf.mem_ready = 1'b1;
    intf.op = OP_LW;
    repeat (3) cyc(P_RST, 1'b1, OP_LW, 1'b0);
    run_instr(OP_LW, 0, 0);
    run_instr(OP_SW, 0, 2);
    run_instr(OP_R, 3, 0);
    run_instr(OP_BEQ, 0, 0);
    run_instr(OP_JAL, 0, 0);
    run_instr(OP_I, 1, 0);
    for (int i = 0; i < 60; i++)
      run_instr(legal[$urandom_range(0, 5)], $urandom_range(0, 3), $urandom_range(0, 3));
    cyc(P_F, 1'b1, 7'($urandom), 1'b1);
    cyc(P_D, 1'b0, OP_LW, 1'b1);
    cyc(P_MA, 1'b1, OP_LW, 1'b1);
    cyc(P_MR, 1'b0, OP_LW, 1'b1);
    cyc(P_RST, 1'b1, OP_LW, 1'b0);
    cyc(P_RST, 1'b1, OP_LW, 1'b0);
    run_instr(OP_LW, 0, 1);
    cyc(P_F, 1'b1, 7'($urandom), 1'b1);
    cyc(P_D, 1'b1, 7'b0110111, 1'b1);
    repeat (12) cyc(P_IL, rb(), 7'($urandom), 1'b1);
    cyc(P_RST, 1'b1, OP_R, 1'b0);
    run_instr(OP_R, 2, 0);
    run_instr(OP_SW, 1, 1);
    @(negedge clk);
    #1;
    total++;
    if (done_seen != done_exp) $display("FAIL done_count got=%0d want=%0d", done_seen, done_exp);
    else passed++;
    total++;
    if (exp_q.size() != 0) $display("FAIL queue_drain left=%0d want=0", exp_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
